fp_recip_round_pack: RTL and testbench
======================================

# fp_recip_round_pack

Final rounding, exponent-range and packing stage of the single-precision reciprocal datapath. It sits directly downstream of the reciprocal mantissa pipeline and consumes that pipeline's per-result bundle:
- pre-round mantissa, guard/round/sticky
- rounding mode, sign, biased result exponent
- special-case bundle

It produces the IEEE-754 binary32 result plus exception flags. Results go into a small output FIFO with a valid/ready handshake, because the upstream pipeline cannot stall.

## Interface
Parameters:
- DEPTH, 4, output FIFO entries; power of 2, ≥2.

Ports (clock and reset: one clock; reset is synchronous and active-low):
- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  synchronous active-low reset.
- valid_in  in  1  input bundle valid this cycle; no backpressure.
- mant_in  in  23  fraction bits, implicit leading 1.
- guard_in, round_in, sticky_in  in  1 each  rounding bits below mant_in[0].
- exp_in  in  10  signed biased result exponent (two's complement).
- sign_in  in  1  result sign.
- rounding_mode  in  3  000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; others behave as RNE.
- special_case  in  1  bypass arithmetic and emit special_result.
- special_result  in  32  precomputed special result.
- input_is_invalid  in  1  operand was sNaN.
- input_is_flushed  in  1  operand was a denormal flushed to zero.
- out  out  32  FIFO head result.
- overflow, underflow, inexact, invalid_operation  out  1 each  FIFO head flags.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts head when out_valid & out_ready.
- fifo_free  out  $clog2(DEPTH)+1  empty entries.
- fifo_overrun  out  1  sticky: a result was dropped.

## Operation
- Stage A (registered): compute the increment inc, then {carry, m} = {1'b0, mant_in} + inc and e = exp_in + carry (m is 0 when carry=1). Register m, e, sign, GRS-nonzero, mode and special bundle.
  - RNE: inc = g & (r | s | mant_in[0])
  - RTZ: inc = 0
  - RDN: inc = sign & (g | r | s)
  - RUP: inc = ~sign & (g | r | s)
  - RMM: inc = g
- Stage B (registered), first match wins:
  - special_case: out = special_result; invalid_operation = input_is_invalid; other flags 0.
  - e ≤ 0 (signed): out = {sign, 31'b0} (flush to zero); underflow = 1; inexact = 1.
  - e ≥ 255: overflow = 1; inexact = 1. out depends on mode:
    - RNE/RMM: ±inf
    - RTZ: ±0x7F7FFFFF
    - RDN: +0x7F7FFFFF or −inf
    - RUP: +inf or −0x7F7FFFFF
  - else: out = {sign, e[7:0], m}; inexact = g | r | s; other flags 0.
- A valid stage-B entry pushes into the FIFO. The FIFO is first-word-fall-through, in-order, with no bypass of an empty FIFO.
- Push while full with no pop: the entry is dropped, fifo_overrun sets and stays set until reset. Push while full with a simultaneous pop: accepted, no overrun.
- Pop and push in the same cycle leave the count unchanged.
- fifo_free = DEPTH − count. The issuing logic uses it to throttle.

## Timing
- Input sampled at edge N.
- Stage A registers at N; stage B registers at N+1; FIFO write at N+2. The result is on out/out_valid after N+2 when the FIFO was empty (3-cycle latency).
- Throughput: 1 result/cycle while out_ready = 1.
- Reset (rst_n = 0 at an edge) clears all stages, FIFO pointers and count, and fifo_overrun.
  - Outputs after reset: out = 0, all flags = 0, out_valid = 0, fifo_free = DEPTH.
  - Results in flight when reset is applied are discarded. valid_in is ignored on reset edges.
- out and flags are stable while out_valid & ~out_ready.

## Configuration
- FP_RECIP_OUT_FIFO_EN defined: FIFO, handshake and overrun behave as described above. Latency is 3.
- Not defined: out, flags and out_valid come straight from the stage-B registers. Latency is 2.
  - out_ready is ignored.
  - fifo_free is tied to DEPTH.
  - fifo_overrun is tied to 0.

## Test plan
- Exact result: mant_in = 0, GRS = 000, exp_in = 126, sign 0, RNE → out 0x3F000000, all flags 0, out_valid 3 cycles after valid_in.
- Rounding carry: mant_in = 0x7FFFFF, g = 1, r = s = 0, exp_in = 127, RNE → out 0x40000000, inexact = 1. Same input with RTZ → 0x3FFFFFFF, inexact = 1.
- Overflow: exp_in = 255, sign 0, RTZ → 0x7F7FFFFF, overflow = 1, inexact = 1. Same input with sign 1, RDN → 0xFF800000.
- Underflow: exp_in = −1, sign 1 → out 0x80000000, underflow = 1, inexact = 1.
- Special: special_case = 1, special_result = 0x7FC00001, input_is_invalid = 1 → out 0x7FC00001, invalid_operation = 1, other flags 0.
- FIFO (DEPTH = 4, macro defined):
  - Setup: out_ready = 0, 5 back-to-back results.
  - Required during stall: fifo_free goes 4 → 0, fifo_overrun = 1.
  - Then raise out_ready: the first 4 results drain in order and out_valid drops to 0.
  - Then pulse rst_n low: fifo_overrun clears and fifo_free = 4.

Source files
------------

// File: rtl/fp_recip_round_pack.sv
// fp_recip_round_pack
//   Final rounding, exponent-range check and IEEE-754 binary32 packing for the
//   single-precision reciprocal datapath. The upstream mantissa pipeline cannot
//   stall, so results land in a small first-word-fall-through output FIFO.
//
//   Pipeline:
//     stage A : rounding increment, mantissa carry into the exponent
//     stage B : special / underflow / overflow / normal selection and packing
//     FIFO    : DEPTH entries, valid/ready head, sticky overrun on a dropped result
//
//   Build option (macro FP_RECIP_OUT_FIFO_EN):
//     defined     -> FIFO + handshake, 3-cycle latency
//     not defined -> out/flags/out_valid straight from stage B, 2-cycle latency;
//                    out_ready ignored, fifo_free = DEPTH, fifo_overrun = 0
//
//   Ports:
//     clk, rst_n                      clock, synchronous active-low reset
//     valid_in                        input bundle valid (no backpressure)
//     mant_in[22:0]                   fraction, implicit leading 1
//     guard_in, round_in, sticky_in   bits below mant_in[0]
//     exp_in[9:0]                     signed biased result exponent
//     sign_in                         result sign
//     rounding_mode[2:0]              000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM, else RNE
//     special_case, special_result    bypass path with precomputed result
//     input_is_invalid                operand was sNaN
//     input_is_flushed                operand was a flushed denormal (informational only)
//     out[31:0], overflow, underflow, inexact, invalid_operation   FIFO head
//     out_valid, out_ready            head handshake
//     fifo_free                       empty FIFO entries
//     fifo_overrun                    sticky: a result was dropped
module fp_recip_round_pack #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     valid_in,
    input  logic [22:0]              mant_in,
    input  logic                     guard_in,
    input  logic                     round_in,
    input  logic                     sticky_in,
    input  logic [9:0]               exp_in,
    input  logic                     sign_in,
    input  logic [2:0]               rounding_mode,
    input  logic                     special_case,
    input  logic [31:0]              special_result,
    input  logic                     input_is_invalid,
    input  logic                     input_is_flushed,
    output logic [31:0]              out,
    output logic                     overflow,
    output logic                     underflow,
    output logic                     inexact,
    output logic                     invalid_operation,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   fifo_free,
    output logic                     fifo_overrun
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [2:0] MODE_RTZ = 3'b001;
    localparam logic [2:0] MODE_RDN = 3'b010;
    localparam logic [2:0] MODE_RUP = 3'b011;
    localparam logic [2:0] MODE_RMM = 3'b100;

    localparam logic [30:0] MAG_INF = 31'h7F80_0000;
    localparam logic [30:0] MAG_MAX = 31'h7F7F_FFFF;

    typedef struct packed {
        logic [31:0] res;
        logic        ovf;
        logic        unf;
        logic        inx;
        logic        inv;
    } res_t;

    // The flushed-operand indication carries no behaviour at this stage; the
    // upstream special-case logic already accounts for it.
    logic unused_flushed;
    assign unused_flushed = input_is_flushed;

    // vld_pipe[0] = stage A valid, vld_pipe[1] = stage B valid
    logic [1:0] vld_pipe;

    // ------------------------------------------------------------------
    // Stage A: rounding increment
    // ------------------------------------------------------------------
    logic        grs_nz;
    logic        inc;
    logic [23:0] mant_sum;
    logic [10:0] exp_rnd;

    assign grs_nz = guard_in | round_in | sticky_in;

    always_comb begin
        inc = 1'b0;
        case (rounding_mode)
            MODE_RTZ: inc = 1'b0;
            MODE_RDN: inc = sign_in & grs_nz;
            MODE_RUP: inc = ~sign_in & grs_nz;
            MODE_RMM: inc = guard_in;
            default:  inc = guard_in & (round_in | sticky_in | mant_in[0]);
        endcase
    end

    // A carry out of the fraction leaves mant_sum[22:0] = 0, which is exactly
    // the renormalised fraction 1.0 at the next exponent. The exponent is
    // widened by one bit so +carry can never wrap a large positive value.
    assign mant_sum = {1'b0, mant_in} + {23'b0, inc};
    assign exp_rnd  = {exp_in[9], exp_in} + {10'b0, mant_sum[23]};

    logic [22:0] a_m;
    logic [10:0] a_e;
    logic        a_sign;
    logic        a_inexact;
    logic [2:0]  a_mode;
    logic        a_special;
    logic [31:0] a_special_result;
    logic        a_invalid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe <= {vld_pipe[0], valid_in};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_m              <= '0;
            a_e              <= '0;
            a_sign           <= 1'b0;
            a_inexact        <= 1'b0;
            a_mode           <= '0;
            a_special        <= 1'b0;
            a_special_result <= '0;
            a_invalid        <= 1'b0;
        end else if (valid_in) begin
            a_m              <= mant_sum[22:0];
            a_e              <= exp_rnd;
            a_sign           <= sign_in;
            a_inexact        <= grs_nz;
            a_mode           <= rounding_mode;
            a_special        <= special_case;
            a_special_result <= special_result;
            a_invalid        <= input_is_invalid;
        end
    end

    // ------------------------------------------------------------------
    // Stage B: range check and packing
    // ------------------------------------------------------------------
    logic e_le0;
    logic e_ge255;
    res_t b_d;
    res_t b_q;

    assign e_le0   = a_e[10] | (a_e == '0);
    assign e_ge255 = ~a_e[10] & (a_e >= 11'd255);

    always_comb begin
        b_d = '0;
        if (a_special) begin
            b_d.res = a_special_result;
            b_d.inv = a_invalid;
        end else if (e_le0) begin
            b_d.res = {a_sign, 31'b0};
            b_d.unf = 1'b1;
            b_d.inx = 1'b1;
        end else if (e_ge255) begin
            b_d.ovf = 1'b1;
            b_d.inx = 1'b1;
            // Directed modes saturate to max-finite on the side they round away from
            case (a_mode)
                MODE_RTZ: b_d.res = {a_sign, MAG_MAX};
                MODE_RDN: b_d.res = a_sign ? {1'b1, MAG_INF} : {1'b0, MAG_MAX};
                MODE_RUP: b_d.res = a_sign ? {1'b1, MAG_MAX} : {1'b0, MAG_INF};
                default:  b_d.res = {a_sign, MAG_INF};
            endcase
        end else begin
            b_d.res = {a_sign, a_e[7:0], a_m};
            b_d.inx = a_inexact;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            b_q <= '0;
        end else if (vld_pipe[0]) begin
            b_q <= b_d;
        end
    end

`ifdef FP_RECIP_OUT_FIFO_EN
    // ------------------------------------------------------------------
    // Output FIFO (first-word-fall-through, no empty bypass)
    // ------------------------------------------------------------------
    res_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          wr_en;
    res_t          head;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign push  = vld_pipe[1];
    assign pop   = ~empty & out_ready;
    // When full, a same-cycle pop frees the slot the write lands in; the
    // read of that slot happens combinationally before the edge.
    assign wr_en = push & (~full | pop);

    always_ff @(posedge clk) begin
        if (rst_n && wr_en) begin
            mem[wr_ptr] <= b_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            fifo_overrun <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            count        <= count + CW'(wr_en) - CW'(pop);
            fifo_overrun <= fifo_overrun | (push & full & ~pop);
        end
    end

    // Head is masked while empty so the idle outputs read as zero without
    // needing to clear the storage array.
    assign head              = empty ? '0 : mem[rd_ptr];
    assign out               = head.res;
    assign overflow          = head.ovf;
    assign underflow         = head.unf;
    assign inexact           = head.inx;
    assign invalid_operation = head.inv;
    assign out_valid         = ~empty;
    assign fifo_free         = CW'(DEPTH) - count;
`else
    logic unused_ready;
    assign unused_ready = out_ready;

    assign out               = b_q.res;
    assign overflow          = b_q.ovf;
    assign underflow         = b_q.unf;
    assign inexact           = b_q.inx;
    assign invalid_operation = b_q.inv;
    assign out_valid         = vld_pipe[1];
    assign fifo_free         = CW'(DEPTH);
    assign fifo_overrun      = 1'b0;
`endif

endmodule

// File: tb/tb_fp_recip_round_pack.sv
// Scoreboard bench for fp_recip_round_pack: directed vectors push their
// hand-computed results into a queue, a negedge monitor pops and compares
// every accepted output. Works with or without FP_RECIP_OUT_FIFO_EN.
module tb_fp_recip_round_pack;

    localparam int DEPTH = 4;
`ifdef FP_RECIP_OUT_FIFO_EN
    localparam int LAT     = 3;
    localparam bit FIFO_EN = 1'b1;
`else
    localparam int LAT     = 2;
    localparam bit FIFO_EN = 1'b0;
`endif

    localparam logic [2:0] RNE = 3'b000, RTZ = 3'b001, RDN = 3'b010, RUP = 3'b011, RMM = 3'b100;
    // flag order {overflow, underflow, inexact, invalid_operation}
    localparam logic [3:0] F0 = 4'b0000, INX = 4'b0010, OVF = 4'b1010, UNF = 4'b0110, INV = 4'b0001;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_in = 1'b0;
    logic [22:0] mant_in = '0;
    logic        guard_in = 1'b0, round_in = 1'b0, sticky_in = 1'b0;
    logic [9:0]  exp_in = '0;
    logic        sign_in = 1'b0;
    logic [2:0]  rounding_mode = '0;
    logic        special_case = 1'b0;
    logic [31:0] special_result = '0;
    logic        input_is_invalid = 1'b0;
    logic        input_is_flushed = 1'b0;
    logic [31:0] out;
    logic        overflow, underflow, inexact, invalid_operation;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [2:0]  fifo_free;
    logic        fifo_overrun;

    fp_recip_round_pack #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .mant_in(mant_in),
        .guard_in(guard_in), .round_in(round_in), .sticky_in(sticky_in),
        .exp_in(exp_in), .sign_in(sign_in), .rounding_mode(rounding_mode),
        .special_case(special_case), .special_result(special_result),
        .input_is_invalid(input_is_invalid), .input_is_flushed(input_is_flushed),
        .out(out), .overflow(overflow), .underflow(underflow), .inexact(inexact),
        .invalid_operation(invalid_operation), .out_valid(out_valid),
        .out_ready(out_ready), .fifo_free(fifo_free), .fifo_overrun(fifo_overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  fl;
        int          issue;
        bit          chk_lat;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, expv);
        end
    endtask

    // Monitor: one comparison set per accepted head
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && (out_ready || !FIFO_EN)) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out: got %h want none", out);
            end else begin
                e = q.pop_front();
                chk("result", out, e.res);
                chk("flags", {28'b0, overflow, underflow, inexact, invalid_operation}, {28'b0, e.fl});
                if (e.chk_lat) chk("latency", cyc - e.issue, LAT);
            end
        end
    end

    task automatic send(input logic [22:0] m, input logic [2:0] grs, input logic [9:0] e,
                        input logic s, input logic [2:0] md, input logic sp,
                        input logic [31:0] spr, input logic inv,
                        input logic [31:0] xres, input logic [3:0] xfl,
                        input bit lat, input bit push_exp);
        exp_t x;
        valid_in = 1'b1;
        mant_in = m;
        {guard_in, round_in, sticky_in} = grs;
        exp_in = e;
        sign_in = s;
        rounding_mode = md;
        special_case = sp;
        special_result = spr;
        input_is_invalid = inv;
        if (push_exp) begin
            x.res = xres;
            x.fl = xfl;
            x.issue = cyc;
            x.chk_lat = lat;
            q.push_back(x);
        end
        @(negedge clk);
        valid_in = 1'b0;
        special_case = 1'b0;
        input_is_invalid = 1'b0;
    endtask

    task automatic norm(input logic [22:0] m, input logic [2:0] grs, input logic [9:0] e,
                        input logic s, input logic [2:0] md,
                        input logic [31:0] xres, input logic [3:0] xfl);
        send(m, grs, e, s, md, 1'b0, 32'h0, 1'b0, xres, xfl, 1'b1, 1'b1);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got %0d pending want 0", name, q.size());
            q.delete();
        end
    endtask

    // FIFO-stall vectors: {0, 127+i, i}
    logic [31:0] fifo_vec [5] = '{32'h3F800000, 32'h40000001, 32'h40800002,
                                  32'h41000003, 32'h41800004};

    initial begin
        // Reset with a valid bundle present: it must be ignored.
        @(negedge clk);
        valid_in = 1'b1;
        exp_in = 10'd127;
        @(negedge clk);
        valid_in = 1'b0;
        rst_n = 1'b1;
        chk("rst_out", out, 32'h0);
        chk("rst_flags", {28'b0, overflow, underflow, inexact, invalid_operation}, 32'h0);
        chk("rst_valid", {31'b0, out_valid}, 32'h0);
        chk("rst_free", {29'b0, fifo_free}, DEPTH);
        chk("rst_overrun", {31'b0, fifo_overrun}, 32'h0);

        // grs = {guard, round, sticky}
        norm(23'h000000, 3'b000, 10'd126, 1'b0, RNE, 32'h3F000000, F0);
        norm(23'h7FFFFF, 3'b100, 10'd127, 1'b0, RNE, 32'h40000000, INX);
        norm(23'h7FFFFF, 3'b100, 10'd127, 1'b0, RTZ, 32'h3FFFFFFF, INX);
        norm(23'h000000, 3'b000, 10'd255, 1'b0, RTZ, 32'h7F7FFFFF, OVF);
        norm(23'h000000, 3'b000, 10'd255, 1'b1, RDN, 32'hFF800000, OVF);
        norm(23'h000000, 3'b000, 10'h3FF, 1'b1, RNE, 32'h80000000, UNF);
        send(23'h0, 3'b000, 10'd300, 1'b0, RNE, 1'b1, 32'h7FC00001, 1'b1,
             32'h7FC00001, INV, 1'b1, 1'b1);
        send(23'h0, 3'b111, 10'h3FF, 1'b1, RNE, 1'b1, 32'h7F800000, 1'b0,
             32'h7F800000, F0, 1'b1, 1'b1);
        norm(23'h000001, 3'b100, 10'd127, 1'b0, RNE, 32'h3F800002, INX);
        norm(23'h000000, 3'b100, 10'd127, 1'b0, RNE, 32'h3F800000, INX);
        norm(23'h000000, 3'b001, 10'd127, 1'b0, RUP, 32'h3F800001, INX);
        norm(23'h000000, 3'b001, 10'd127, 1'b1, RUP, 32'hBF800000, INX);
        norm(23'h000000, 3'b010, 10'd127, 1'b1, RDN, 32'hBF800001, INX);
        norm(23'h000000, 3'b100, 10'd127, 1'b0, RMM, 32'h3F800001, INX);
        norm(23'h000001, 3'b100, 10'd100, 1'b0, 3'b111, 32'h32000002, INX);
        norm(23'h000000, 3'b000, 10'd0,   1'b0, RNE, 32'h00000000, UNF);
        norm(23'h7FFFFF, 3'b100, 10'd254, 1'b0, RNE, 32'h7F800000, OVF);
        norm(23'h7FFFFF, 3'b000, 10'd254, 1'b0, RNE, 32'h7F7FFFFF, F0);
        norm(23'h000000, 3'b000, 10'd1,   1'b0, RNE, 32'h00800000, F0);
        norm(23'h000000, 3'b000, 10'd255, 1'b1, RUP, 32'hFF7FFFFF, OVF);
        norm(23'h000000, 3'b000, 10'd255, 1'b0, RUP, 32'h7F800000, OVF);
        norm(23'h000000, 3'b000, 10'd255, 1'b0, RDN, 32'h7F7FFFFF, OVF);
        norm(23'h000000, 3'b000, 10'd255, 1'b1, RMM, 32'hFF800000, OVF);
        norm(23'h7FFFFF, 3'b100, 10'd0,   1'b0, RNE, 32'h00800000, INX);
        norm(23'h7FFFFF, 3'b100, 10'h3FF, 1'b0, RNE, 32'h00000000, UNF);
        drain("directed");
        repeat (4) @(negedge clk);
        chk("idle_valid", {31'b0, out_valid}, 32'h0);

        if (FIFO_EN) begin
            out_ready = 1'b0;
            chk("stall_free_start", {29'b0, fifo_free}, DEPTH);
            // Writes land two edges after issue; only the first DEPTH fit.
            for (int i = 0; i < 8; i++) begin
                if (i < 5) send(23'(i), 3'b000, 10'(127 + i), 1'b0, RNE, 1'b0, 32'h0, 1'b0,
                                fifo_vec[i], F0, 1'b0, i < DEPTH);
                else @(negedge clk);
                chk("stall_free", {29'b0, fifo_free},
                    DEPTH - ((i < 1) ? 0 : ((i - 1 > DEPTH) ? DEPTH : i - 1)));
                chk("stall_overrun", {31'b0, fifo_overrun}, (i >= 6) ? 1 : 0);
            end
            chk("stall_head", out, 32'h3F800000);
            chk("stall_valid", {31'b0, out_valid}, 32'h1);
            out_ready = 1'b1;
            drain("fifo");
            @(negedge clk);
            chk("drained_valid", {31'b0, out_valid}, 32'h0);
            chk("drained_free", {29'b0, fifo_free}, DEPTH);
            chk("overrun_sticky", {31'b0, fifo_overrun}, 32'h1);
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            chk("rst2_overrun", {31'b0, fifo_overrun}, 32'h0);
            chk("rst2_free", {29'b0, fifo_free}, DEPTH);
        end else begin
            out_ready = 1'b0;
            norm(23'h000000, 3'b000, 10'd126, 1'b1, RNE, 32'hBF000000, F0);
            drain("direct");
            chk("direct_free", {29'b0, fifo_free}, DEPTH);
            chk("direct_overrun", {31'b0, fifo_overrun}, 32'h0);
            out_ready = 1'b1;
        end

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
